// File: rtl/pulse_conditioner_pkg.sv
// pulse_conditioner_pkg: debounce FSM states and edge-mode selectors
package pulse_conditioner_pkg;
    typedef enum logic [1:0] {ST_LO, ST_CHK_HI, ST_HI, ST_CHK_LO} state_t;
    typedef logic [1:0] edge_mode_t;
    localparam edge_mode_t EDGE_RISE = 2'd0;
    localparam edge_mode_t EDGE_FALL = 2'd1;
    localparam edge_mode_t EDGE_BOTH = 2'd2;
endpackage

// File: rtl/pulse_conditioner_sync_ff.sv
// sync_ff: reusable multi-stage synchronizer for asynchronous board inputs
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) r <= '0;
        else r <= {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronize, debounce and strobe a raw input for the downstream pulse counter
module pulse_conditioner
    import pulse_conditioner_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter int         DEBOUNCE_CYC = 200_000,
    parameter edge_mode_t EDGE_MODE    = EDGE_RISE
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       sig_in,
    output logic       pulse_out,
    output logic       level_out,
    output logic       glitch_out,
    output logic [7:0] glitch_cnt_out
);
    localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYC - 1);
    logic          s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          at_end, rise_ok, fall_ok, bounce, hold;
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .d       (sig_in),
        .q       (s)
    );
    assign at_end  = cnt == CNT_END;
    assign rise_ok = state == ST_CHK_HI && s && at_end;
    assign fall_ok = state == ST_CHK_LO && !s && at_end;
    assign bounce  = (state == ST_CHK_HI && !s) || (state == ST_CHK_LO && s);
    // a bounce drops back to the stable state, so the window always restarts from zero
    assign hold    = (state == ST_CHK_HI || state == ST_CHK_LO) && state_nxt == state;
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LO:     state_nxt = s ? ST_CHK_HI : ST_LO;
            ST_CHK_HI: state_nxt = !s ? ST_LO : at_end ? ST_HI : ST_CHK_HI;
            ST_HI:     state_nxt = !s ? ST_CHK_LO : ST_HI;
            ST_CHK_LO: state_nxt = s ? ST_HI : at_end ? ST_LO : ST_CHK_LO;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            state          <= ST_LO;
            cnt            <= '0;
            level_out      <= 1'b0;
            pulse_out      <= 1'b0;
            glitch_out     <= 1'b0;
            glitch_cnt_out <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= hold ? cnt + 1'b1 : '0;
            level_out      <= rise_ok | (level_out & ~fall_ok);
            pulse_out      <= (rise_ok && EDGE_MODE != EDGE_FALL) || (fall_ok && EDGE_MODE != EDGE_RISE);
            glitch_out     <= bounce;
            glitch_cnt_out <= glitch_cnt_out + 8'(bounce && glitch_cnt_out != 8'hFF);
        end
endmodule

// File: tb/tb_pulse_conditioner.sv
// tb_pulse_conditioner: directed and random checks of three edge-mode variants against a run-length model
module tb_pulse_conditioner;
    import pulse_conditioner_pkg::*;
    localparam int D = 4;
    localparam int SYNC = 2;
    logic clk_in = 0, rst_n_in = 0, sig_in = 0;
    logic pr, lr, gr, pf, lf, gf, pb, lb, gb;
    logic [7:0] cr, cf, cb;
    int total = 0, bad = 0, edge_n = 0;
    bit h0, h1, lvl, e_pr, e_pf, e_pb, e_gl, samp;
    int run, gcnt;
    int lat, np, ng, e_first, e_second;

    always #5 clk_in = ~clk_in;

    pulse_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYC(D), .EDGE_MODE(EDGE_RISE)) dut_r (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sig_in(sig_in),
        .pulse_out(pr), .level_out(lr), .glitch_out(gr), .glitch_cnt_out(cr));
    pulse_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYC(D), .EDGE_MODE(EDGE_FALL)) dut_f (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sig_in(sig_in),
        .pulse_out(pf), .level_out(lf), .glitch_out(gf), .glitch_cnt_out(cf));
    pulse_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYC(D), .EDGE_MODE(EDGE_BOTH)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sig_in(sig_in),
        .pulse_out(pb), .level_out(lb), .glitch_out(gb), .glitch_cnt_out(cb));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task model_reset;
        h0 = 0; h1 = 0; lvl = 0; run = 0; gcnt = 0;
        e_pr = 0; e_pf = 0; e_pb = 0; e_gl = 0;
    endtask

    task check_all;
        chk("level_r", lr, lvl);  chk("level_f", lf, lvl);  chk("level_b", lb, lvl);
        chk("pulse_r", pr, e_pr); chk("pulse_f", pf, e_pf); chk("pulse_b", pb, e_pb);
        chk("glitch_r", gr, e_gl); chk("glitch_f", gf, e_gl); chk("glitch_b", gb, e_gl);
        chk("gcnt_r", cr, gcnt);  chk("gcnt_f", cf, gcnt);  chk("gcnt_b", cb, gcnt);
    endtask

    // model: a level is accepted once D+1 consecutive samples of the synchronized input disagree with it
    task tick;
        @(posedge clk_in);
        edge_n++;
        if (rst_n_in) begin
            samp = h1; h1 = h0; h0 = sig_in;
            e_pr = 0; e_pf = 0; e_pb = 0; e_gl = 0;
            if (samp != lvl) begin
                run++;
                if (run == D + 1) begin
                    lvl = samp; run = 0;
                    e_pr = samp; e_pf = !samp; e_pb = 1;
                end
            end else if (run > 0) begin
                run = 0; e_gl = 1;
                if (gcnt < 255) gcnt++;
            end
        end
        @(negedge clk_in);
        check_all();
    endtask

    task do_reset;
        rst_n_in = 0;
        #1;
        model_reset();
        check_all();
        tick(); tick();
        rst_n_in = 1;
    endtask

    initial begin
        @(negedge clk_in);
        do_reset();

        // clean rise, then clean fall
        sig_in = 1; lat = -1; np = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pr && lat < 0) lat = i + 1;
            np += int'(pr);
        end
        chk("rise_latency", lat, SYNC + D + 1);
        chk("rise_pulses", np, 1);
        chk("rise_level", lr, 1);
        chk("rise_gcnt", cr, 0);
        sig_in = 0; lat = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pf && lat < 0) lat = i + 1;
        end
        chk("fall_latency", lat, SYNC + D + 1);
        chk("fall_level", lf, 0);

        // bounce then settle high
        do_reset();
        np = 0; ng = 0;
        sig_in = 1; repeat (2) begin tick(); np += int'(pr); ng += int'(gr); end
        sig_in = 0; repeat (3) begin tick(); np += int'(pr); ng += int'(gr); end
        sig_in = 1; repeat (15) begin tick(); np += int'(pr); ng += int'(gr); end
        chk("bounce_glitches", ng, 1);
        chk("bounce_gcnt", cr, 1);
        chk("bounce_pulses", np, 1);
        chk("bounce_level", lr, 1);

        // both edges of a 20-cycle pulse
        do_reset();
        np = 0; e_first = -1; e_second = -1;
        sig_in = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) sig_in = 0;
            tick();
            if (pb) begin
                np++;
                if (e_first < 0) e_first = edge_n; else e_second = edge_n;
            end
        end
        chk("both_pulses", np, 2);
        chk("both_spacing", e_second - e_first, 20);
        chk("both_level", lb, 0);

        // glitch counter saturation
        do_reset();
        np = 0; ng = 0;
        repeat (300) begin
            sig_in = 1; repeat (2) begin tick(); ng += int'(gb); np += int'(pr | pf | pb); end
            sig_in = 0; repeat (3) begin tick(); ng += int'(gb); np += int'(pr | pf | pb); end
        end
        chk("sat_glitches", ng, 300);
        chk("sat_gcnt", cb, 255);
        chk("sat_pulses", np, 0);

        // reset while confirming a rise with cnt==2
        do_reset();
        sig_in = 1;
        repeat (5) tick();
        do_reset();
        lat = -1; np = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pr && lat < 0) lat = i + 1;
            np += int'(pr);
        end
        chk("rst_mid_latency", lat, SYNC + D + 1);
        chk("rst_mid_pulses", np, 1);

        // ten clean events counted downstream
        do_reset();
        np = 0;
        repeat (10) begin
            sig_in = 1; repeat (8) begin tick(); np += int'(pr); end
            sig_in = 0; repeat (8) begin tick(); np += int'(pr); end
        end
        chk("downstream_count", np, 10);

        // random bursts against the model
        do_reset();
        repeat (60) begin
            sig_in = ~sig_in;
            repeat ($urandom_range(1, 8)) tick();
        end
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_conditioner.md
# pulse_conditioner

Conditions a raw, asynchronous, possibly bouncing input (button, opto, external sensor) into a clean single-cycle strobe suitable for the 1 s window pulse counter directly downstream. The counter adds one per high cycle of its input, so the input must be synchronous, debounced, and exactly one cycle wide per event. The block synchronizes the input, debounces it with a confirm-window FSM, and emits `pulse_out` on the selected edge(s). It also provides the debounced level and a saturating count of rejected glitches for the LED and debug outputs.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth; minimum 2.
- `DEBOUNCE_CYC`, 200_000: cycles the synchronized level must stay stable before it is accepted; minimum 1 (1 ms at 200 MHz).
- `EDGE_MODE`, `EDGE_RISE`: `EDGE_RISE`, `EDGE_FALL` or `EDGE_BOTH`, selecting which accepted transitions produce `pulse_out`.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: asynchronous reset, active-low; clock is `clk_in`.
- `sig_in` in 1: raw asynchronous input.
- `pulse_out` out 1: one-cycle strobe per accepted transition of the selected polarity.
- `level_out` out 1: debounced level.
- `glitch_out` out 1: one-cycle strobe when a candidate transition is rejected.
- `glitch_cnt_out` out 8: rejected-transition count, saturating at 255.

## Operation
- Synchronizer: `SYNC_STAGES` flops, all reset to 0. Its last stage is `s`. No other logic samples `sig_in`.
- FSM states:
  - `ST_LO`: stable low.
  - `ST_CHK_HI`: confirming a rise.
  - `ST_HI`: stable high.
  - `ST_CHK_LO`: confirming a fall.
- Transitions and counter `cnt`:
  - `ST_LO` with s=1: go to `ST_CHK_HI` and set cnt=0.
  - `ST_CHK_HI` with s=0: go to `ST_LO`, pulse `glitch_out`, increment the glitch count.
  - `ST_CHK_HI` with s=1 and cnt==DEBOUNCE_CYC-1: go to `ST_HI` and set `level_out`=1. Pulse `pulse_out` if EDGE_MODE is RISE or BOTH.
  - `ST_CHK_HI`, otherwise: cnt+1.
  - `ST_HI` and `ST_CHK_LO` mirror the above with polarity inverted. Pulse `pulse_out` on acceptance into `ST_LO` if EDGE_MODE is FALL or BOTH.
- `cnt` width is `$clog2(DEBOUNCE_CYC)`, minimum 1 bit. `cnt` never exceeds DEBOUNCE_CYC-1 and never wraps.
- The glitch counter is 8 bits and saturates at 255. It holds at 255 while `glitch_out` still pulses.
- A bounce inside a confirm window restarts the process from the stable state: the window is not resumed.
- Reset value of every output is 0. The FSM resets to `ST_LO` and cnt resets to 0.
- Reset mid-confirm aborts: no `pulse_out`, no `glitch_out`.
- If `sig_in` is high at reset release, the block runs a normal rise confirmation and emits a rising pulse. This is intentional: the downstream counter resets too.
- All outputs are registered. `pulse_out` and `glitch_out` never assert in the same cycle.

## Timing
- Let t0 be the first edge at which s=1.
  - Entry to `ST_CHK_HI` happens at t0+1 with cnt=0.
  - `level_out` rises at edge t0+DEBOUNCE_CYC+1.
  - `pulse_out` is high for exactly the cycle between edges t0+DEBOUNCE_CYC+1 and t0+DEBOUNCE_CYC+2.
- End-to-end latency from the first `clk_in` edge sampling `sig_in` high is SYNC_STAGES+DEBOUNCE_CYC+1 cycles.
- Falling edges have the same latency.
- A glitch is reported one edge after s returns to the old level.
- Minimum spacing between two `pulse_out` with EDGE_MODE=BOTH is DEBOUNCE_CYC+1 cycles.
- `pulse_out` is always one cycle wide, so the downstream counter adds exactly 1 per event.

## Structure
- `pulse_conditioner_pkg` holds:
  - `state_t` enum (`ST_LO`, `ST_CHK_HI`, `ST_HI`, `ST_CHK_LO`), 2 bits.
  - `edge_mode_t` constants `EDGE_RISE`=0, `EDGE_FALL`=1, `EDGE_BOTH`=2.
- One sub-module, `sync_ff`: parameterised-depth synchronizer chain with asynchronous active-low reset to 0. It is reusable for other external inputs on the board.
- FSM, counters and output registers live in a single `always_ff` block plus next-state logic in the top.

## Test plan
Sim parameters: SYNC_STAGES=2, DEBOUNCE_CYC=4.
- Clean rise, EDGE_RISE: `sig_in` 0→1 and held → `level_out`=1 and a single `pulse_out` at 7 cycles after the first sampling edge; `glitch_cnt_out`=0.
- Bounce: `sig_in` high 2 cycles, low 3, then high held → one `glitch_out`, `glitch_cnt_out`=1, then exactly one `pulse_out`; `level_out`=1.
- EDGE_BOTH: a clean 20-cycle high pulse → two `pulse_out` strobes (rise and fall), spaced 20 cycles apart; `level_out` returns to 0.
- Saturation: 300 two-cycle glitches → `glitch_cnt_out`=255 and stays 255; 300 `glitch_out` strobes; `pulse_out` never asserts.
- Reset mid-confirm: assert `rst_n_in` while in `ST_CHK_HI` with cnt=2 → all outputs 0 immediately; after release with `sig_in` still high, `pulse_out` at 7 cycles.
- Downstream integration: 10 clean events inside one counter window → the pulse counter displays 10.
